rnn_mem_arbiter: RTL and testbench

- Shares the single RNN weight/state memory port (mce/maddr/msel/mdata_w/mdata_r) between two requesters.
- Requester A is the RNN compute core; requester B is the host load/readback engine.
- Arbitration is round-robin and burst-based, with a forced hand-over after MAX_BURST beats and release of an idle owner.
- Read data returns tagged to the requester that issued the read.

---
 rtl/rnn_mem_arbiter.sv | 205 ++++++++++++++++++++
 tb/tb_rnn_mem_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rnn_mem_arbiter.sv
// rnn_mem_arbiter
//   Shares the single RNN weight/state memory port between two requesters:
//   A is the RNN compute core, B is the host load/readback engine.
//   Ownership is burst based and round-robin. An owner is forced off after
//   MAX_BURST beats if the other side is waiting, and loses the grant after
//   IDLE_TO consecutive cycles without a request. Read data comes back
//   tagged to whichever requester issued the read.
//
// Ports
//   clk, reset            rising-edge clock, asynchronous active-low reset
//   {a,b}_req/_sel/_addr/_wdata/_last   beat request side of each requester
//   {a,b}_gnt             registered ownership flags
//   {a,b}_rvalid/_rdata   read return for each requester
//   mce/maddr/msel/mdata_w   memory beat outputs (address/data hold when idle)
//   mdata_r               memory read data, READ_LAT cycles after a read beat
module rnn_mem_arbiter #(
  parameter int unsigned MAX_BURST = 64,
  parameter int unsigned IDLE_TO   = 4,
  parameter int unsigned READ_LAT  = 1,
  parameter logic [2:0]  MSEL_WR   = 3'b101
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        a_req,
  input  logic [2:0]  a_sel,
  input  logic [16:0] a_addr,
  input  logic [19:0] a_wdata,
  input  logic        a_last,
  output logic        a_gnt,
  output logic        a_rvalid,
  output logic [19:0] a_rdata,
  input  logic        b_req,
  input  logic [2:0]  b_sel,
  input  logic [16:0] b_addr,
  input  logic [19:0] b_wdata,
  input  logic        b_last,
  output logic        b_gnt,
  output logic        b_rvalid,
  output logic [19:0] b_rdata,
  output logic        mce,
  output logic [16:0] maddr,
  output logic [2:0]  msel,
  output logic [19:0] mdata_w,
  input  logic [19:0] mdata_r
);

  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_e;

  localparam logic [7:0] MaxBurst = 8'(MAX_BURST);
  localparam logic [3:0] IdleTo   = 4'(IDLE_TO);

  state_e      state_q;
  logic        rrIsB_q;
  logic [7:0]  beatCnt_q;
  logic [3:0]  idleCnt_q;
  logic [16:0] maddr_q;
  logic [2:0]  msel_q;
  logic [19:0] mdataW_q;
  logic [19:0] aRdata_q;
  logic [19:0] bRdata_q;
  logic [READ_LAT-1:0] tagValid_q;
  logic [READ_LAT-1:0] tagOwnerB_q;

  logic        aBeat, bBeat, beat;
  logic        ownReq, othReq, ownLast, relOwner;
  logic [7:0]  cntInc;
  logic [3:0]  idleInc;
  logic [16:0] beatAddr;
  logic [2:0]  beatSel;
  logic [19:0] beatWdata;
  logic        pipeValid, pipeOwnerB;

  // Grants come straight from the state register, so they are glitch free
  // and a beat is simply "owner is requesting this cycle".
  assign a_gnt = (state_q == OWN_A);
  assign b_gnt = (state_q == OWN_B);
  assign aBeat = a_gnt & a_req;
  assign bBeat = b_gnt & b_req;
  assign beat  = aBeat | bBeat;

  // Owner/competitor view of the request lines, plus the release decision
  // for the cycle: last beat, burst limit with a waiting competitor, or the
  // owner has gone quiet for too long. The beat count saturates at the limit
  // so an uncontested owner keeps streaming.
  always_comb begin
    ownReq   = b_gnt ? b_req  : a_req;
    othReq   = b_gnt ? a_req  : b_req;
    ownLast  = b_gnt ? b_last : a_last;
    cntInc   = (beatCnt_q >= MaxBurst) ? MaxBurst : beatCnt_q + 8'd1;
    idleInc  = idleCnt_q + 4'd1;
    relOwner = 1'b0;
    if (ownReq) begin
      relOwner = ownLast || ((cntInc == MaxBurst) && othReq);
    end else begin
      relOwner = (idleInc == IdleTo);
    end
  end

  // Memory port mux. Without a beat the address/select/data hold the last
  // issued values so the memory side sees no needless toggling.
  always_comb begin
    beatAddr  = bBeat ? b_addr  : a_addr;
    beatSel   = bBeat ? b_sel   : a_sel;
    beatWdata = bBeat ? b_wdata : a_wdata;
    mce       = beat;
    maddr     = beat ? beatAddr  : maddr_q;
    msel      = beat ? beatSel   : msel_q;
    mdata_w   = beat ? beatWdata : mdataW_q;
  end

  // Ownership FSM with round-robin pointer and the burst/idle counters.
  // rrIsB_q names the side that wins a tie in IDLE. A release hands the port
  // straight to a waiting competitor with no IDLE bubble, and the pointer is
  // then aimed back at the side that just gave the port up.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      rrIsB_q   <= 1'b0;
      beatCnt_q <= 8'd0;
      idleCnt_q <= 4'd0;
    end else begin
      case (state_q)
        IDLE: begin
          beatCnt_q <= 8'd0;
          idleCnt_q <= 4'd0;
          if (a_req && b_req) begin
            state_q <= rrIsB_q ? OWN_B : OWN_A;
            rrIsB_q <= ~rrIsB_q;
          end else if (a_req) begin
            state_q <= OWN_A;
          end else if (b_req) begin
            state_q <= OWN_B;
          end
        end
        OWN_A, OWN_B: begin
          if (relOwner) begin
            beatCnt_q <= 8'd0;
            idleCnt_q <= 4'd0;
            if (othReq) begin
              state_q <= (state_q == OWN_A) ? OWN_B : OWN_A;
              rrIsB_q <= (state_q == OWN_B);
            end else begin
              state_q <= IDLE;
            end
          end else if (ownReq) begin
            beatCnt_q <= cntInc;
            idleCnt_q <= 4'd0;
          end else begin
            idleCnt_q <= idleInc;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Hold registers for the memory-side outputs, refreshed on every beat.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      maddr_q  <= 17'd0;
      msel_q   <= 3'd0;
      mdataW_q <= 20'd0;
    end else if (beat) begin
      maddr_q  <= beatAddr;
      msel_q   <= beatSel;
      mdataW_q <= beatWdata;
    end
  end

  // Read tag pipe, one stage per cycle of memory latency. Each entry records
  // whether that cycle issued a read and who issued it, so returns land on
  // the right requester even after the grant has moved on.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tagValid_q  <= '0;
      tagOwnerB_q <= '0;
    end else begin
      tagValid_q[0]  <= beat && (beatSel != MSEL_WR);
      tagOwnerB_q[0] <= bBeat;
      for (int i = 1; i < int'(READ_LAT); i++) begin
        tagValid_q[i]  <= tagValid_q[i-1];
        tagOwnerB_q[i] <= tagOwnerB_q[i-1];
      end
    end
  end

  assign pipeValid  = tagValid_q[READ_LAT-1];
  assign pipeOwnerB = tagOwnerB_q[READ_LAT-1];
  assign a_rvalid   = pipeValid & ~pipeOwnerB;
  assign b_rvalid   = pipeValid &  pipeOwnerB;
  assign a_rdata    = a_rvalid ? mdata_r : aRdata_q;
  assign b_rdata    = b_rvalid ? mdata_r : bRdata_q;

  // Each side's read data holds its most recent return between reads.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      aRdata_q <= 20'd0;
      bRdata_q <= 20'd0;
    end else begin
      if (a_rvalid) aRdata_q <= mdata_r;
      if (b_rvalid) bRdata_q <= mdata_r;
    end
  end

endmodule

// File: tb/tb_rnn_mem_arbiter.sv
// tb_rnn_mem_arbiter
//   Drives rnn_mem_arbiter with directed scenarios and randomized traffic and
//   compares every cycle against a behavioural model of ownership, beats and
//   tagged read returns. A small memory model answers reads with a word
//   derived from the address.
module tb_rnn_mem_arbiter;

  localparam int         MB = 4;
  localparam int         IT = 4;
  localparam int         RL = 3;
  localparam logic [2:0] WR = 3'b101;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_req, a_last, b_req, b_last;
  logic [2:0]  a_sel, b_sel;
  logic [16:0] a_addr, b_addr;
  logic [19:0] a_wdata, b_wdata;
  logic        a_gnt, a_rvalid, b_gnt, b_rvalid;
  logic [19:0] a_rdata, b_rdata;
  logic        mce;
  logic [16:0] maddr;
  logic [2:0]  msel;
  logic [19:0] mdata_w, mdata_r;

  int checks = 0;
  int fails  = 0;

  rnn_mem_arbiter #(.MAX_BURST(MB), .IDLE_TO(IT), .READ_LAT(RL), .MSEL_WR(WR)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_sel(a_sel), .a_addr(a_addr), .a_wdata(a_wdata), .a_last(a_last),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_sel(b_sel), .b_addr(b_addr), .b_wdata(b_wdata), .b_last(b_last),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .mce(mce), .maddr(maddr), .msel(msel), .mdata_w(mdata_w), .mdata_r(mdata_r)
  );

  always #5 clk = ~clk;

  function automatic logic [19:0] memWord(input logic [16:0] ad);
    return {3'b000, ad} ^ {ad[9:0], 10'h000} ^ 20'h5A3C9;
  endfunction

  // Memory model: answers the beat seen on the port RL cycles later
  logic [19:0] memPipe [RL];
  always @(posedge clk) begin
    memPipe[0] <= mce ? memWord(maddr) : 20'h0;
    for (int i = 1; i < RL; i++) memPipe[i] <= memPipe[i-1];
  end
  assign mdata_r = memPipe[RL-1];

  // Reference model state
  typedef struct {
    int          due;
    bit          toB;
    logic [16:0] addr;
  } rd_t;
  rd_t         rdQ[$];
  int          cyc;
  int          mOwner;
  bit          mRrB;
  int          mCnt, mIdle;
  logic [16:0] eMaddr;
  logic [2:0]  eMsel;
  logic [19:0] eMdw, eARd, eBRd;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic modelReset();
    mOwner = 0; mRrB = 1'b0; mCnt = 0; mIdle = 0;
    rdQ.delete();
    eMaddr = '0; eMsel = '0; eMdw = '0; eARd = '0; eBRd = '0;
  endtask

  task automatic driveA(input logic r, input logic [2:0] s, input logic [16:0] ad,
                        input logic [19:0] wd, input logic l);
    a_req = r; a_sel = s; a_addr = ad; a_wdata = wd; a_last = l;
  endtask

  task automatic driveB(input logic r, input logic [2:0] s, input logic [16:0] ad,
                        input logic [19:0] wd, input logic l);
    b_req = r; b_sel = s; b_addr = ad; b_wdata = wd; b_last = l;
  endtask

  task automatic applyStimulus(input int pA, input int pB, input int pLast);
    driveA(($urandom_range(99) < pA), ($urandom_range(3) == 0) ? WR : 3'($urandom),
           17'($urandom), 20'($urandom), ($urandom_range(99) < pLast));
    driveB(($urandom_range(99) < pB), ($urandom_range(3) == 0) ? WR : 3'($urandom),
           17'($urandom), 20'($urandom), ($urandom_range(99) < pLast));
  endtask

  // Compare this cycle's outputs with the model, then advance the model
  // across the coming clock edge.
  task automatic evaluateCycle();
    bit   beatA, beatB, expAv, expBv, ownReq, othReq, ownLast, rel;
    int   own;
    beatA = (mOwner == 1) && a_req;
    beatB = (mOwner == 2) && b_req;
    if (beatA) begin
      eMaddr = a_addr; eMsel = a_sel; eMdw = a_wdata;
    end else if (beatB) begin
      eMaddr = b_addr; eMsel = b_sel; eMdw = b_wdata;
    end
    expAv = 1'b0; expBv = 1'b0;
    if (rdQ.size() > 0 && rdQ[0].due == cyc) begin
      if (rdQ[0].toB) begin expBv = 1'b1; eBRd = memWord(rdQ[0].addr); end
      else            begin expAv = 1'b1; eARd = memWord(rdQ[0].addr); end
      void'(rdQ.pop_front());
    end
    checkOutput("gnt",      64'({a_gnt, b_gnt}), 64'({mOwner == 1, mOwner == 2}));
    checkOutput("mce",      64'(mce),      64'(beatA | beatB));
    checkOutput("maddr",    64'(maddr),    64'(eMaddr));
    checkOutput("msel",     64'(msel),     64'(eMsel));
    checkOutput("mdata_w",  64'(mdata_w),  64'(eMdw));
    checkOutput("a_rvalid", 64'(a_rvalid), 64'(expAv));
    checkOutput("b_rvalid", 64'(b_rvalid), 64'(expBv));
    checkOutput("a_rdata",  64'(a_rdata),  64'(eARd));
    checkOutput("b_rdata",  64'(b_rdata),  64'(eBRd));
    if ((beatA || beatB) && eMsel != WR) rdQ.push_back('{cyc + RL, beatB, eMaddr});

    if (mOwner == 0) begin
      if (a_req && b_req) begin
        mOwner = mRrB ? 2 : 1;
        mRrB   = !mRrB;
      end else if (a_req) mOwner = 1;
      else if (b_req) mOwner = 2;
    end else begin
      own     = mOwner;
      ownReq  = (own == 1) ? a_req  : b_req;
      othReq  = (own == 1) ? b_req  : a_req;
      ownLast = (own == 1) ? a_last : b_last;
      if (ownReq) begin
        mCnt  = (mCnt < MB) ? mCnt + 1 : MB;
        mIdle = 0;
        rel   = ownLast || (mCnt == MB && othReq);
      end else begin
        mIdle++;
        rel = (mIdle >= IT);
      end
      if (rel) begin
        mCnt = 0; mIdle = 0;
        if (othReq) begin
          mRrB   = (own == 2);
          mOwner = 3 - own;
        end else begin
          mOwner = 0;
        end
      end
    end
    cyc++;
  endtask

  task automatic runCycle();
    #1;
    evaluateCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_req_side"},
                64'({a_gnt, a_rvalid, a_rdata, b_gnt, b_rvalid, b_rdata}), 64'(0));
    checkOutput({tag, "_mem_side"}, 64'({mce, maddr, msel, mdata_w}), 64'(0));
  endtask

  initial begin
    reset = 1'b0;
    driveA(0, 3'd0, 17'd0, 20'd0, 0);
    driveB(0, 3'd0, 17'd0, 20'd0, 0);
    cyc = 0;
    modelReset();
    repeat (4) @(posedge clk);
    #1;
    checkResetOutputs("reset");
    reset = 1'b1;

    // Both request together: A wins the tie, four reads, then B with no gap
    for (int i = 0; i < 5; i++) begin
      driveA(1, 3'b001, 17'((i == 0) ? 0 : i - 1), 20'(i), (i == 4));
      driveB(1, 3'b010, 17'h100 + 17'(i), 20'h0, 0);
      runCycle();
    end
    // B streams uncontested, then goes quiet while A posts writes
    for (int i = 0; i < 6; i++) begin
      driveB(1, 3'b011, 17'h200 + 17'(i), 20'h0, 0);
      driveA(0, 3'b000, 17'h0, 20'h0, 0);
      runCycle();
    end
    for (int i = 0; i < 9; i++) begin
      driveB(0, 3'b000, 17'h0, 20'h0, 0);
      driveA(1, WR, 17'h01040, 20'h0ABCD, (i == 8));
      runCycle();
    end
    // Burst limit with a waiting competitor: ping-pong every MB beats
    for (int i = 0; i < 18; i++) begin
      driveA(1, 3'b000, 17'($urandom), 20'($urandom), 0);
      driveB(1, 3'b110, 17'($urandom), 20'($urandom), 0);
      runCycle();
    end
    // A alone keeps streaming past the burst limit
    for (int i = 0; i < 12; i++) begin
      driveA(1, 3'b100, 17'($urandom), 20'($urandom), 0);
      driveB(0, 3'b000, 17'h0, 20'h0, 0);
      runCycle();
    end
    // A drops its request: idle timeout to IDLE, then idle timeout to B
    for (int i = 0; i < 7; i++) begin
      driveA(0, 3'b000, 17'h0, 20'h0, 0);
      runCycle();
    end
    for (int i = 0; i < 3; i++) begin
      driveA(1, 3'b001, 17'h300 + 17'(i), 20'h0, 0);
      runCycle();
    end
    for (int i = 0; i < 8; i++) begin
      driveA(0, 3'b001, 17'h0, 20'h0, 0);
      driveB(1, 3'b010, 17'h400 + 17'(i), 20'h0, (i == 7));
      runCycle();
    end
    // Reset mid-burst with A reads still in flight
    for (int i = 0; i < 10; i++) begin
      driveA(1, 3'b010, 17'h500 + 17'(i), 20'h0, 0);
      driveB(0, 3'b000, 17'h0, 20'h0, 0);
      runCycle();
    end
    #2;
    reset = 1'b0;
    #1;
    checkResetOutputs("midreset");
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    modelReset();
    for (int i = 0; i < 6; i++) begin
      driveA(0, 3'b000, 17'h0, 20'h0, 0);
      runCycle();
    end

    // Randomized traffic with varying request and last densities
    for (int seg = 0; seg < 10; seg++) begin
      int pA, pB, pL;
      pA = 20 + int'($urandom_range(80));
      pB = 20 + int'($urandom_range(80));
      pL = int'($urandom_range(30));
      for (int i = 0; i < 200; i++) begin
        applyStimulus(pA, pB, pL);
        runCycle();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
